// File: rtl/shifter_operand_stage_if.sv
// Request/response bundle between register-read and the shifter operand stage.
// The master side issues operands and consumes results; the slave side is the stage.
interface shifter_operand_stage_if #(
   parameter int WIDTH = 32,
   parameter int IMM_W = 8,
   parameter int ROT_W = 4,
   parameter int SH_W  = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       sel;
   logic [IMM_W-1:0] immed_8;
   logic [ROT_W-1:0] rotate_imm;
   logic [WIDTH-1:0] immed_32;
   logic [WIDTH-1:0] rm;
   logic [WIDTH-1:0] rs;
   logic [1:0]       shift_type;
   logic             shift_reg;
   logic [SH_W-1:0]  shift_imm;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] shiftee;
   logic [WIDTH-1:0] shifter_out;
   logic             carry_out;
   logic             sel_err;

   modport master (
      output in_valid, sel, immed_8, rotate_imm, immed_32, rm, rs,
             shift_type, shift_reg, shift_imm, carry_in, out_ready,
      input  in_ready, out_valid, shiftee, shifter_out, carry_out, sel_err
   );

   modport slave (
      input  in_valid, sel, immed_8, rotate_imm, immed_32, rm, rs,
             shift_type, shift_reg, shift_imm, carry_in, out_ready,
      output in_ready, out_valid, shiftee, shifter_out, carry_out, sel_err
   );
endinterface

// File: rtl/shifter_operand_stage.sv
// Pipelined ARM data-processing shifter operand stage: shiftee select plus barrel
// shift, registered valid/ready output, register-specified shifts take an extra cycle.
module shifter_operand_stage #(
   parameter int WIDTH = 32,
   parameter int IMM_W = 8,
   parameter int ROT_W = 4,
   parameter int SH_W  = $clog2(WIDTH)
) (
   input logic clk,
   input logic rst_n,
   input logic flush,
   shifter_operand_stage_if.slave bus
);

   typedef enum logic {IDLE, REGSH} state_t;

   localparam logic [1:0] SEL_IMM8  = 2'b00;
   localparam logic [1:0] SEL_RM    = 2'b01;
   localparam logic [1:0] SEL_IMM32 = 2'b10;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   state_t state, next_state;

   logic             out_valid_q;
   logic [WIDTH-1:0] shiftee_q;
   logic [WIDTH-1:0] shifter_out_q;
   logic             carry_out_q;
   logic             sel_err_q;

   logic [WIDTH-1:0] lat_rm;
   logic [7:0]       lat_amt;
   logic [1:0]       lat_type;
   logic             lat_cin;

   logic             in_ready_c;
   logic             load_out;
   logic             latch_en;

   logic [WIDTH-1:0] d_shiftee;
   logic [WIDTH-1:0] d_result;
   logic             d_carry;
   logic             d_err;

   function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] v, input int r);
      if (r == 0)
         return v;
      return (v >> r) | (v << (WIDTH - r));
   endfunction

   // Returns {carry, result}. k==0 means no shift; k may exceed WIDTH for register
   // amounts, where the widened shifts naturally produce the saturated results.
   function automatic logic [WIDTH:0] barrel(input logic [WIDTH-1:0] v, input logic [1:0] ty,
                                             input int k, input logic cin);
      logic [WIDTH:0]        t;
      logic signed [WIDTH:0] s;
      logic [WIDTH-1:0]      res;
      int                    kk;
      int                    r;
      if (k == 0)
         return {cin, v};
      case (ty)
         SH_LSL: begin
            t = {1'b0, v} << k;
            return t;
         end
         SH_LSR: begin
            t = {v, 1'b0} >> k;
            return {t[0], t[WIDTH:1]};
         end
         SH_ASR: begin
            kk = (k > WIDTH) ? WIDTH : k;
            s  = $signed({v, 1'b0});
            t  = s >>> kk;
            return {t[0], t[WIDTH:1]};
         end
         default: begin
            r   = k % WIDTH;
            res = ror_w(v, r);
            return {res[WIDTH-1], res};
         end
      endcase
   endfunction

   // Result datapath: latched operands while finishing a register shift, live inputs otherwise.
   always_comb begin
      logic [WIDTH:0] t;
      int             k;
      int             n;
      d_shiftee = '0;
      d_result  = '0;
      d_carry   = bus.carry_in;
      d_err     = 1'b0;
      t         = '0;
      k         = 0;
      n         = int'(bus.shift_imm);
      if (state == REGSH) begin
         d_shiftee = lat_rm;
         t         = barrel(lat_rm, lat_type, int'(lat_amt), lat_cin);
         d_result  = t[WIDTH-1:0];
         d_carry   = t[WIDTH];
      end else begin
         case (bus.sel)
            SEL_IMM8: begin
               d_shiftee = WIDTH'(bus.immed_8);
               d_result  = ror_w(d_shiftee, (2 * int'(bus.rotate_imm)) % WIDTH);
               d_carry   = (bus.rotate_imm == '0) ? bus.carry_in : d_result[WIDTH-1];
            end
            SEL_RM: begin
               d_shiftee = bus.rm;
               if (bus.shift_reg) begin
                  t = barrel(bus.rm, bus.shift_type, int'(bus.rs[7:0]), bus.carry_in);
               end else if (n == 0 && bus.shift_type == SH_ROR) begin
                  t = {bus.rm[0], bus.carry_in, bus.rm[WIDTH-1:1]};
               end else begin
                  k = (n == 0 && (bus.shift_type == SH_LSR || bus.shift_type == SH_ASR)) ? WIDTH : n;
                  t = barrel(bus.rm, bus.shift_type, k, bus.carry_in);
               end
               d_result = t[WIDTH-1:0];
               d_carry  = t[WIDTH];
            end
            SEL_IMM32: begin
               d_shiftee = bus.immed_32;
               d_result  = bus.immed_32;
            end
            default: d_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Handshake control: IDLE accepts when the output slot is free or draining,
   // REGSH waits for the slot before delivering its result.
   always_comb begin
      next_state = state;
      in_ready_c = 1'b0;
      load_out   = 1'b0;
      latch_en   = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = rst_n && (!out_valid_q || bus.out_ready);
            if (bus.in_valid && in_ready_c) begin
               if (bus.sel == SEL_RM && bus.shift_reg) begin
                  latch_en   = 1'b1;
                  next_state = REGSH;
               end else begin
                  load_out = 1'b1;
               end
            end
         end
         REGSH: begin
            if (!out_valid_q || bus.out_ready) begin
               load_out   = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (flush) begin
         next_state = IDLE;
         load_out   = 1'b0;
         latch_en   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_rm   <= '0;
         lat_amt  <= '0;
         lat_type <= '0;
         lat_cin  <= 1'b0;
      end else if (latch_en) begin
         lat_rm   <= bus.rm;
         lat_amt  <= bus.rs[7:0];
         lat_type <= bus.shift_type;
         lat_cin  <= bus.carry_in;
      end
   end

   // Flush only drops valid; the data registers keep their last contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         shiftee_q     <= '0;
         shifter_out_q <= '0;
         carry_out_q   <= 1'b0;
         sel_err_q     <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load_out) begin
         out_valid_q   <= 1'b1;
         shiftee_q     <= d_shiftee;
         shifter_out_q <= d_result;
         carry_out_q   <= d_carry;
         sel_err_q     <= d_err;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.shiftee     = shiftee_q;
   assign bus.shifter_out = shifter_out_q;
   assign bus.carry_out   = carry_out_q;
   assign bus.sel_err     = sel_err_q;

   generate
      if (WIDTH > 8) begin : g_rs_high
         logic unused_rs_high;
         assign unused_rs_high = ^bus.rs[WIDTH-1:8];
      end
   endgenerate

endmodule

// File: tb/tb_shifter_operand_stage.sv
// Self-checking bench for shifter_operand_stage: directed corner cases plus a
// randomized run scored against a behavioural model of the ARM shifter operand rules.
module tb_shifter_operand_stage;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] shiftee;
      logic [W-1:0] result;
      logic         carry;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic flush;

   int tests = 0;
   int failures = 0;
   exp_t q[$];

   shifter_operand_stage_if #(.WIDTH(W), .IMM_W(8), .ROT_W(4), .SH_W(5)) bus ();

   shifter_operand_stage #(.WIDTH(W), .IMM_W(8), .ROT_W(4), .SH_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int r);
      logic [W-1:0] x;
      x = v;
      for (int i = 0; i < r; i++)
         x = {x[0], x[W-1:1]};
      return x;
   endfunction

   function automatic logic [W-1:0] asr(input logic [W-1:0] v, input int a);
      logic [W-1:0] x;
      x = v >> a;
      if (v[W-1])
         x = x | ~(32'hFFFF_FFFF >> a);
      return x;
   endfunction

   function automatic exp_t refModel(input logic [1:0] sel, input logic [7:0] i8, input logic [3:0] rot,
                                     input logic [W-1:0] i32, input logic [W-1:0] rm, input logic [W-1:0] rs,
                                     input logic [1:0] ty, input logic sreg, input logic [4:0] simm,
                                     input logic cin);
      exp_t e;
      int   n;
      int   a;
      e.shiftee = '0;
      e.result  = '0;
      e.carry   = cin;
      e.err     = 1'b0;
      n = int'(simm);
      a = int'(rs[7:0]);
      case (sel)
         2'b00: begin
            e.shiftee = {24'd0, i8};
            e.result  = rotr(e.shiftee, (2 * int'(rot)) % W);
            e.carry   = (rot == 4'd0) ? cin : e.result[W-1];
         end
         2'b10: begin
            e.shiftee = i32;
            e.result  = i32;
         end
         2'b11: e.err = 1'b1;
         default: begin
            e.shiftee = rm;
            if (!sreg) begin
               case (ty)
                  2'b00: if (n == 0) begin e.result = rm; e.carry = cin; end
                         else begin e.result = rm << n; e.carry = rm[W-n]; end
                  2'b01: if (n == 0) begin e.result = '0; e.carry = rm[W-1]; end
                         else begin e.result = rm >> n; e.carry = rm[n-1]; end
                  2'b10: if (n == 0) begin e.result = {W{rm[W-1]}}; e.carry = rm[W-1]; end
                         else begin e.result = asr(rm, n); e.carry = rm[n-1]; end
                  default: if (n == 0) begin e.result = {cin, rm[W-1:1]}; e.carry = rm[0]; end
                           else begin e.result = rotr(rm, n); e.carry = e.result[W-1]; end
               endcase
            end else if (a == 0) begin
               e.result = rm;
               e.carry  = cin;
            end else begin
               case (ty)
                  2'b00: if (a < W) begin e.result = rm << a; e.carry = rm[W-a]; end
                         else if (a == W) begin e.result = '0; e.carry = rm[0]; end
                         else begin e.result = '0; e.carry = 1'b0; end
                  2'b01: if (a < W) begin e.result = rm >> a; e.carry = rm[a-1]; end
                         else if (a == W) begin e.result = '0; e.carry = rm[W-1]; end
                         else begin e.result = '0; e.carry = 1'b0; end
                  2'b10: if (a < W) begin e.result = asr(rm, a); e.carry = rm[a-1]; end
                         else begin e.result = {W{rm[W-1]}}; e.carry = rm[W-1]; end
                  default: if (a % W == 0) begin e.result = rm; e.carry = rm[W-1]; end
                           else begin e.result = rotr(rm, a % W); e.carry = e.result[W-1]; end
               endcase
            end
         end
      endcase
      return e;
   endfunction

   task automatic applyStimulus(input logic [1:0] s, input logic [7:0] i8, input logic [3:0] rot,
                                input logic [W-1:0] i32, input logic [W-1:0] r_m, input logic [W-1:0] r_s,
                                input logic [1:0] ty, input logic sreg, input logic [4:0] simm,
                                input logic cin);
      bus.in_valid   = 1'b1;
      bus.sel        = s;
      bus.immed_8    = i8;
      bus.rotate_imm = rot;
      bus.immed_32   = i32;
      bus.rm         = r_m;
      bus.rs         = r_s;
      bus.shift_type = ty;
      bus.shift_reg  = sreg;
      bus.shift_imm  = simm;
      bus.carry_in   = cin;
   endtask

   function automatic exp_t currentExpected();
      return refModel(bus.sel, bus.immed_8, bus.rotate_imm, bus.immed_32, bus.rm, bus.rs,
                      bus.shift_type, bus.shift_reg, bus.shift_imm, bus.carry_in);
   endfunction

   // One clock: score handshakes just before the edge, then return 1 time unit after it.
   task automatic tick();
      logic acc;
      logic del;
      exp_t e;
      #1;
      acc = bus.in_valid && bus.in_ready;
      del = bus.out_valid && bus.out_ready;
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         if (q.size() == 0)
            checkOutput("idle_valid", {63'd0, bus.out_valid}, 64'd0);
         if (del) begin
            checkOutput("sb_pending", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               checkOutput("sb_shiftee", {32'd0, bus.shiftee}, {32'd0, e.shiftee});
               checkOutput("sb_result", {32'd0, bus.shifter_out}, {32'd0, e.result});
               checkOutput("sb_carry", {63'd0, bus.carry_out}, {63'd0, e.carry});
               checkOutput("sb_sel_err", {63'd0, bus.sel_err}, {63'd0, e.err});
            end
         end
         if (acc)
            q.push_back(currentExpected());
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] randAmount();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd31;
         2: return 32'd32;
         3: return 32'd33;
         4: return 32'd64;
         5: return {$urandom, 8'hFF} & 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] rsVals[3];
      logic [1:0]   tyVals[3];
      logic [W-1:0] expRes[3];
      logic         expCar[3];
      logic [W-1:0] holdVal;
      exp_t         eb;

      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.out_ready = 1'b1;
      applyStimulus(2'b10, 8'h5A, 4'd3, 32'hDEAD_BEEF, 32'h1234_5678, 32'd7, 2'b00, 1'b0, 5'd3, 1'b1);

      // Reset with a pending request
      tick();
      tick();
      checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("rst_shifter_out", {32'd0, bus.shifter_out}, 64'd0);
      checkOutput("rst_shiftee", {32'd0, bus.shiftee}, 64'd0);
      checkOutput("rst_carry", {63'd0, bus.carry_out}, 64'd0);
      checkOutput("rst_sel_err", {63'd0, bus.sel_err}, 64'd0);
      checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      checkOutput("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Rotated immediate
      applyStimulus(2'b00, 8'hFF, 4'd4, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      checkOutput("imm8_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("imm8_result", {32'd0, bus.shifter_out}, 64'hFF00_0000);
      checkOutput("imm8_carry", {63'd0, bus.carry_out}, 64'd1);
      checkOutput("imm8_shiftee", {32'd0, bus.shiftee}, 64'h0000_00FF);

      // Immediate-amount zero encodings
      applyStimulus(2'b01, 8'd0, 4'd0, 32'd0, 32'h8000_0001, 32'd0, 2'b01, 1'b0, 5'd0, 1'b0);
      tick();
      checkOutput("lsr0_result", {32'd0, bus.shifter_out}, 64'd0);
      checkOutput("lsr0_carry", {63'd0, bus.carry_out}, 64'd1);
      applyStimulus(2'b01, 8'd0, 4'd0, 32'd0, 32'h8000_0001, 32'd0, 2'b11, 1'b0, 5'd0, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      checkOutput("rrx_result", {32'd0, bus.shifter_out}, 64'hC000_0000);
      checkOutput("rrx_carry", {63'd0, bus.carry_out}, 64'd1);

      // Register-specified shifts: two-cycle latency, busy in between
      rsVals = '{32'd32, 32'd33, 32'd32};
      tyVals = '{2'b00, 2'b00, 2'b11};
      expRes = '{32'h0, 32'h0, 32'h8000_0001};
      expCar = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(2'b01, 8'd0, 4'd0, 32'd0, 32'h8000_0001, rsVals[i], tyVals[i], 1'b1, 5'd0, 1'b0);
         tick();
         checkOutput("regsh_busy_valid", {63'd0, bus.out_valid}, 64'd0);
         checkOutput("regsh_in_ready", {63'd0, bus.in_ready}, 64'd0);
         bus.in_valid = 1'b0;
         tick();
         checkOutput("regsh_valid", {63'd0, bus.out_valid}, 64'd1);
         checkOutput("regsh_result", {32'd0, bus.shifter_out}, {32'd0, expRes[i]});
         checkOutput("regsh_carry", {63'd0, bus.carry_out}, {63'd0, expCar[i]});
      end
      tick();

      // Backpressure with back-to-back immediate ops
      bus.out_ready = 1'b0;
      holdVal = $urandom;
      applyStimulus(2'b10, 8'd0, 4'd0, holdVal, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b0);
      tick();
      applyStimulus(2'b00, 8'($urandom), 4'($urandom), 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 5'd0, 1'b1);
      eb = currentExpected();
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
         checkOutput("bp_valid", {63'd0, bus.out_valid}, 64'd1);
         checkOutput("bp_hold", {32'd0, bus.shifter_out}, {32'd0, holdVal});
      end
      bus.out_ready = 1'b1;
      tick();
      checkOutput("bp_next_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("bp_next_result", {32'd0, bus.shifter_out}, {32'd0, eb.result});
      applyStimulus(2'b01, 8'd0, 4'd0, 32'd0, $urandom, 32'd0, 2'b10, 1'b0, 5'd7, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();

      // Flush during a register shift
      applyStimulus(2'b01, 8'd0, 4'd0, 32'd0, 32'h1234_5678, 32'd4, 2'b00, 1'b1, 5'd0, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush_valid", {63'd0, bus.out_valid}, 64'd0);
      checkOutput("flush_idle", {63'd0, bus.in_ready}, 64'd1);
      tick();
      checkOutput("flush_still_idle", {63'd0, bus.out_valid}, 64'd0);

      // Reserved select
      applyStimulus(2'b11, 8'hAB, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 2'b00, 1'b0, 5'd1, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      checkOutput("rsv_sel_err", {63'd0, bus.sel_err}, 64'd1);
      checkOutput("rsv_result", {32'd0, bus.shifter_out}, 64'd0);
      checkOutput("rsv_shiftee", {32'd0, bus.shiftee}, 64'd0);
      checkOutput("rsv_carry", {63'd0, bus.carry_out}, 64'd1);
      tick();

      // Randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         applyStimulus(2'($urandom), 8'($urandom), 4'($urandom), $urandom, $urandom, randAmount(),
                       2'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                       1'($urandom));
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 39) == 0);
         if (flush)
            bus.out_ready = 1'b0;
         tick();
      end

      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && q.size() != 0; i++)
         tick();
      checkOutput("drain_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
